sb_edge_param: RTL and testbench
================================

SB_EDGE_PARAM -- requirements
Module: sb_edge_param

Interface
REQ-001 Parameter CHAN_WIDTH, default 9, is the tracks per channel side; legal range is 2..64.
REQ-002 Parameter SEL_W, fixed at 2, is the select bits per output mux.
REQ-003 Derived constant CFG_BITS = 2*CHAN_WIDTH*SEL_W is the configuration chain length; it is 36 at the default.
REQ-004 The ports SHALL be exactly these, in this order:
- prog_clk  in  1  Single clock for configuration and output register.
- prog_reset  in  1  Reset, synchronous, active-high.
- chanx_right_in  in  CHAN_WIDTH  Right channel tracks in.
- chany_bottom_in  in  CHAN_WIDTH  Bottom channel tracks in.
- right_pin  in  CHAN_WIDTH  Grid pins feeding right-side muxes.
- bottom_pin  in  CHAN_WIDTH  Grid pins feeding bottom-side muxes.
- ccff_head  in  1  Serial configuration data in.
- cfg_shift  in  1  Shift enable for the shadow chain.
- cfg_commit  in  1  Copy the shadow chain to the active selects.
- cfg_clear  in  1  Clear the bit counter and the error flag.
- chanx_right_out  out  CHAN_WIDTH  Right channel tracks out.
- chany_bottom_out  out  CHAN_WIDTH  Bottom channel tracks out.
- ccff_tail  out  1  Last shadow bit, for daisy-chaining.
- cfg_done  out  1  One-cycle pulse on an accepted commit.
- cfg_err  out  1  Sticky flag for a rejected commit.

Function
REQ-005 Mux i on each side SHALL select by its active 2-bit code:
- 00: drive 0.
- 01: the pin[i] for that side.
- 10: the twisted track of the opposite channel.
- 11: the straight track, i.e. index i of the opposite channel.
REQ-006 Twisted index SHALL be CHAN_WIDTH-2-i for i<CHAN_WIDTH-1, and CHAN_WIDTH-1 for i=CHAN_WIDTH-1.
REQ-007 The opposite channel for a right output SHALL be chany_bottom_in; for a bottom output it SHALL be chanx_right_in.
REQ-008 When cfg_shift=1, each cycle SHALL shift ccff_head into shadow bit 0, with shadow[k] moving to shadow[k+1]; ccff_tail SHALL equal shadow[CFG_BITS-1].
REQ-009 Shadow order SHALL be right mux 0..CHAN_WIDTH-1, then bottom mux 0..CHAN_WIDTH-1; within each mux, bit 1 is the MSB.
REQ-010 A bit counter SHALL increment on each shift and saturate at CFG_BITS+1.
REQ-011 The counter SHALL drive a state machine with these states:
- EMPTY: count=0.
- PARTIAL: 0<count<CFG_BITS.
- FULL: count=CFG_BITS.
- OVER: count>CFG_BITS.
REQ-012 A commit in FULL SHALL copy shadow to active on the next edge, pulse cfg_done for one cycle, and return to EMPTY; the shadow contents are kept.
REQ-013 A commit in EMPTY, PARTIAL or OVER SHALL leave active unchanged, set cfg_err, and leave the counter unchanged.
REQ-014 If cfg_commit and cfg_shift are asserted in the same cycle, commit SHALL take priority and the shift SHALL be ignored.
REQ-015 cfg_clear SHALL zero the counter and cfg_err without touching shadow or active; if it coincides with a commit, cfg_clear SHALL win.
REQ-016 Active selects SHALL change only on an accepted commit; outputs SHALL reflect the new selects starting from the edge after the commit edge.

Reset
REQ-017 On prog_reset, shadow, active, counter, cfg_done and cfg_err SHALL all be 0, and the state SHALL be EMPTY.
REQ-018 Since active resets to 0 (code 00), chanx_right_out and chany_bottom_out SHALL be 0 while in reset and after it.
REQ-019 Reset asserted mid-shift SHALL discard the partial load; the next load restarts from EMPTY.

Configuration
REQ-020 With SB_OUT_REG_EN defined, both output buses SHALL be registered on prog_clk, adding 1 cycle of latency; the register resets to 0.
REQ-021 Without SB_OUT_REG_EN, both output buses SHALL be combinational from the inputs and the active selects, with 0 cycles of latency.

Structure
REQ-022 Package sb_pkg SHALL hold:
- the select-code constants (SEL_OFF, SEL_PIN, SEL_TWIST, SEL_STRAIGHT);
- the state enum;
- a function computing the twisted index.
REQ-023 Sub-module sb_cfg_chain SHALL contain the shadow register, counter, state machine and active register; the top level holds the muxes and the optional output register.

Verification
REQ-024 Reset, then drive every input to 1: both output buses SHALL read 0.
REQ-025 Shift 36 bits coding every mux as 01, then commit: cfg_done pulses once, chanx_right_out equals right_pin and chany_bottom_out equals bottom_pin.
REQ-026 Code every mux as 10 and set chany_bottom_in=9'b0_0000_0001: chanx_right_out[7]=1 and all other chanx_right_out bits are 0.
REQ-027 Shift 35 bits then commit: cfg_err=1 and the outputs are unchanged; after cfg_clear, a full 36-bit load is accepted.
REQ-028 Shift 37 bits then commit: cfg_err=1; commit together with shift in FULL is accepted and the counter stays at 0.
REQ-029 Run REQ-025 with and without SB_OUT_REG_EN: the outputs update 1 cycle later when the macro is defined.

Source files
------------

// File: rtl/sb_pkg.sv
// Shared definitions for the switch-block edge tile: mux select codes,
// configuration-load state encoding and the twisted-track index helper.
package sb_pkg;

  // Per-mux select codes (2 bits, bit 1 is the MSB)
  localparam logic [1:0] SEL_OFF      = 2'b00;
  localparam logic [1:0] SEL_PIN      = 2'b01;
  localparam logic [1:0] SEL_TWIST    = 2'b10;
  localparam logic [1:0] SEL_STRAIGHT = 2'b11;

  // Load progress of the shadow chain, derived from the shifted-bit count
  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL,
    OVER
  } cfg_state_t;

  // Twisted track: mirror all but the last track, which maps onto itself
  function automatic int twist_idx(input int idx, input int width);
    return (idx < width - 1) ? (width - 2 - idx) : (width - 1);
  endfunction

endpackage

// File: rtl/sb_edge_param_if.sv
// Configuration bus of the switch-block tile: serial data in, control
// strobes, and the status/daisy-chain signals coming back.
interface sb_edge_param_if;

  logic ccff_head;
  logic cfg_shift;
  logic cfg_commit;
  logic cfg_clear;
  logic ccff_tail;
  logic cfg_done;
  logic cfg_err;

  // Master drives the load, slave (the configuration chain) answers
  modport master (
    output ccff_head, cfg_shift, cfg_commit, cfg_clear,
    input  ccff_tail, cfg_done, cfg_err
  );

  modport slave (
    input  ccff_head, cfg_shift, cfg_commit, cfg_clear,
    output ccff_tail, cfg_done, cfg_err
  );

endinterface

// File: rtl/sb_cfg_chain.sv
// Configuration chain: shadow shift register, saturating bit counter,
// load-state machine and the active select register. Active selects only
// change on a commit issued when exactly CFG_BITS bits have been shifted.
module sb_cfg_chain
  import sb_pkg::*;
#(
  parameter int CFG_BITS = 36
) (
  input  logic                prog_clk,
  input  logic                prog_reset,
  sb_edge_param_if.slave      cfg,
  output logic [CFG_BITS-1:0] active
);

  // Counter must hold CFG_BITS+1 (the saturation value)
  localparam int CNT_W = $clog2(CFG_BITS + 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CFG_BITS - 1);

  logic [CFG_BITS-1:0] shadow_reg;
  logic [CFG_BITS-1:0] active_reg;
  logic [CNT_W-1:0]    count_reg;
  cfg_state_t          state_reg;
  logic                done_reg;
  logic                err_reg;

  // Load FSM: clear beats commit, commit beats shift; count saturates in OVER
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      shadow_reg <= '0;
      active_reg <= '0;
      count_reg  <= '0;
      state_reg  <= EMPTY;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (cfg.cfg_clear) begin
        count_reg <= '0;
        state_reg <= EMPTY;
        err_reg   <= 1'b0;
      end else if (cfg.cfg_commit) begin
        if (state_reg == FULL) begin
          active_reg <= shadow_reg;
          done_reg   <= 1'b1;
          count_reg  <= '0;
          state_reg  <= EMPTY;
        end else begin
          err_reg <= 1'b1;
        end
      end else if (cfg.cfg_shift) begin
        shadow_reg <= {shadow_reg[CFG_BITS-2:0], cfg.ccff_head};
        if (state_reg != OVER) begin
          count_reg <= count_reg + 1'b1;
        end
        case (state_reg)
          EMPTY:   state_reg <= PARTIAL;
          PARTIAL: state_reg <= (count_reg == LAST_CNT) ? FULL : PARTIAL;
          FULL:    state_reg <= OVER;
          default: state_reg <= OVER;
        endcase
      end
    end
  end

  assign active        = active_reg;
  assign cfg.ccff_tail = shadow_reg[CFG_BITS-1];
  assign cfg.cfg_done  = done_reg;
  assign cfg.cfg_err   = err_reg;

endmodule

// File: rtl/sb_edge_param.sv
// Switch-block edge tile: one 4:1 mux per track on the right and bottom
// sides, selecting off / grid pin / twisted track / straight track of the
// opposite channel. Selects come from a serially loaded configuration chain.
// Optional macro SB_OUT_REG_EN registers both output buses (one extra cycle).
module sb_edge_param
  import sb_pkg::*;
#(
  parameter int CHAN_WIDTH = 9,
  parameter int SEL_W      = 2
) (
  input  logic                  prog_clk,
  input  logic                  prog_reset,
  input  logic [CHAN_WIDTH-1:0] chanx_right_in,
  input  logic [CHAN_WIDTH-1:0] chany_bottom_in,
  input  logic [CHAN_WIDTH-1:0] right_pin,
  input  logic [CHAN_WIDTH-1:0] bottom_pin,
  input  logic                  ccff_head,
  input  logic                  cfg_shift,
  input  logic                  cfg_commit,
  input  logic                  cfg_clear,
  output logic [CHAN_WIDTH-1:0] chanx_right_out,
  output logic [CHAN_WIDTH-1:0] chany_bottom_out,
  output logic                  ccff_tail,
  output logic                  cfg_done,
  output logic                  cfg_err
);

  // Right muxes occupy the low half of the chain, bottom muxes the high half
  localparam int CFG_BITS = 2 * CHAN_WIDTH * SEL_W;

  sb_edge_param_if cfg_bus ();

  assign cfg_bus.ccff_head  = ccff_head;
  assign cfg_bus.cfg_shift  = cfg_shift;
  assign cfg_bus.cfg_commit = cfg_commit;
  assign cfg_bus.cfg_clear  = cfg_clear;
  assign ccff_tail          = cfg_bus.ccff_tail;
  assign cfg_done           = cfg_bus.cfg_done;
  assign cfg_err            = cfg_bus.cfg_err;

  logic [CFG_BITS-1:0] active;

  sb_cfg_chain #(
    .CFG_BITS (CFG_BITS)
  ) u_chain (
    .prog_clk   (prog_clk),
    .prog_reset (prog_reset),
    .cfg        (cfg_bus),
    .active     (active)
  );

  function automatic logic sel_mux(input logic [SEL_W-1:0] code, input logic pin,
                                   input logic twist, input logic straight);
    logic res;
    res = 1'b0;
    case (code)
      SEL_OFF:      res = 1'b0;
      SEL_PIN:      res = pin;
      SEL_TWIST:    res = twist;
      SEL_STRAIGHT: res = straight;
      default:      res = 1'b0;
    endcase
    return res;
  endfunction

  logic [CHAN_WIDTH-1:0] right_mux;
  logic [CHAN_WIDTH-1:0] bottom_mux;

  for (genvar gi = 0; gi < CHAN_WIDTH; gi++) begin : g_mux
    localparam int TW = twist_idx(gi, CHAN_WIDTH);

    // Right output reads the bottom channel, bottom output reads the right channel
    assign right_mux[gi] = sel_mux(active[SEL_W*gi +: SEL_W], right_pin[gi],
                                   chany_bottom_in[TW], chany_bottom_in[gi]);
    assign bottom_mux[gi] = sel_mux(active[SEL_W*(CHAN_WIDTH+gi) +: SEL_W], bottom_pin[gi],
                                    chanx_right_in[TW], chanx_right_in[gi]);
  end

`ifdef SB_OUT_REG_EN
  // Output register: one cycle of latency, cleared by reset
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      chanx_right_out  <= '0;
      chany_bottom_out <= '0;
    end else begin
      chanx_right_out  <= right_mux;
      chany_bottom_out <= bottom_mux;
    end
  end
`else
  assign chanx_right_out  = right_mux;
  assign chany_bottom_out = bottom_mux;
`endif

endmodule

// File: tb/tb_sb_edge_param.sv
// Self-checking bench for sb_edge_param at CHAN_WIDTH=9 (36 configuration bits).
// Expected outputs come from a bench-side model of the chain and muxes and
// are queued when stimulus is driven, then popped when the outputs are sampled.
module tb_sb_edge_param;

  localparam int W  = 9;
  localparam int NB = 2 * W * 2;
`ifdef SB_OUT_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  typedef struct {
    string        tag;
    logic [W-1:0] x;
    logic [W-1:0] y;
  } exp_t;

  logic         prog_clk = 1'b0;
  logic         prog_reset;
  logic [W-1:0] chanx_right_in, chany_bottom_in, right_pin, bottom_pin;
  logic [W-1:0] chanx_right_out, chany_bottom_out;

  sb_edge_param_if bus ();

  int n_checks = 0;
  int n_errors = 0;

  logic [NB-1:0] m_shadow;
  logic [NB-1:0] m_active;
  int            m_count;
  logic          m_err;
  exp_t          sb_q[$];

  always #5 prog_clk = ~prog_clk;

  sb_edge_param dut (
    .prog_clk         (prog_clk),
    .prog_reset       (prog_reset),
    .chanx_right_in   (chanx_right_in),
    .chany_bottom_in  (chany_bottom_in),
    .right_pin        (right_pin),
    .bottom_pin       (bottom_pin),
    .ccff_head        (bus.ccff_head),
    .cfg_shift        (bus.cfg_shift),
    .cfg_commit       (bus.cfg_commit),
    .cfg_clear        (bus.cfg_clear),
    .chanx_right_out  (chanx_right_out),
    .chany_bottom_out (chany_bottom_out),
    .ccff_tail        (bus.ccff_tail),
    .cfg_done         (bus.cfg_done),
    .cfg_err          (bus.cfg_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // side 0 = right output (opposite channel chany_bottom_in), side 1 = bottom
  function automatic logic [W-1:0] model_side(input logic [NB-1:0] act, input int side,
                                              input logic [W-1:0] opp, input logic [W-1:0] pin);
    logic [W-1:0] r;
    logic [1:0]   c;
    int           tw;
    r = '0;
    for (int i = 0; i < W; i++) begin
      c  = act[side*2*W + 2*i +: 2];
      tw = (i < W - 1) ? (W - 2 - i) : (W - 1);
      case (c)
        2'b00: r[i] = 1'b0;
        2'b01: r[i] = pin[i];
        2'b10: r[i] = opp[tw];
        default: r[i] = opp[i];
      endcase
    end
    return r;
  endfunction

  function automatic logic [W-1:0] exp_x(input logic [NB-1:0] act);
    return model_side(act, 0, chany_bottom_in, right_pin);
  endfunction

  function automatic logic [W-1:0] exp_y(input logic [NB-1:0] act);
    return model_side(act, 1, chanx_right_in, bottom_pin);
  endfunction

  task automatic check_outputs(input string tag, input logic [W-1:0] cx, input logic [W-1:0] cy,
                               input logic [W-1:0] rp, input logic [W-1:0] bp);
    exp_t e;
    @(negedge prog_clk);
    chanx_right_in  = cx;
    chany_bottom_in = cy;
    right_pin       = rp;
    bottom_pin      = bp;
    sb_q.push_back('{tag, exp_x(m_active), exp_y(m_active)});
    @(negedge prog_clk);
    e = sb_q.pop_front();
    check({e.tag, "_x"}, 64'(chanx_right_out), 64'(e.x));
    check({e.tag, "_y"}, 64'(chany_bottom_out), 64'(e.y));
  endtask

  task automatic check_random(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      check_outputs(tag, W'($urandom()), W'($urandom()), W'($urandom()), W'($urandom()));
    end
  endtask

  // Shift n bits, image bits MSB first so a full load leaves shadow == word
  task automatic shift_bits(input logic [NB-1:0] word, input int n);
    logic b;
    for (int j = 0; j < n; j++) begin
      if (j < NB) b = word[NB-1-j];
      else        b = 1'($urandom_range(0, 1));
      @(negedge prog_clk);
      bus.ccff_head = b;
      bus.cfg_shift = 1'b1;
      m_shadow = {m_shadow[NB-2:0], b};
      if (m_count < NB + 1) m_count++;
    end
    @(negedge prog_clk);
    bus.cfg_shift = 1'b0;
    bus.ccff_head = 1'b0;
    check("tail", 64'(bus.ccff_tail), 64'(m_shadow[NB-1]));
  endtask

  task automatic commit_op(input string tag, input logic with_shift, input logic with_clear);
    logic [W-1:0] old_x, old_y, new_x, new_y;
    logic         exp_done;
    @(negedge prog_clk);
    old_x = exp_x(m_active);
    old_y = exp_y(m_active);
    bus.cfg_commit = 1'b1;
    bus.cfg_shift  = with_shift;
    bus.cfg_clear  = with_clear;
    bus.ccff_head  = 1'($urandom_range(0, 1));
    exp_done = 1'b0;
    if (with_clear) begin
      m_count = 0;
      m_err   = 1'b0;
    end else if (m_count == NB) begin
      m_active = m_shadow;
      m_count  = 0;
      exp_done = 1'b1;
    end else begin
      m_err = 1'b1;
    end
    new_x = exp_x(m_active);
    new_y = exp_y(m_active);
    @(negedge prog_clk);
    check({tag, "_done"}, 64'(bus.cfg_done), 64'(exp_done));
    check({tag, "_err"}, 64'(bus.cfg_err), 64'(m_err));
    check({tag, "_lat_x"}, 64'(chanx_right_out), 64'((LAT == 1) ? old_x : new_x));
    check({tag, "_lat_y"}, 64'(chany_bottom_out), 64'((LAT == 1) ? old_y : new_y));
    bus.cfg_commit = 1'b0;
    bus.cfg_shift  = 1'b0;
    bus.cfg_clear  = 1'b0;
    bus.ccff_head  = 1'b0;
    @(negedge prog_clk);
    check({tag, "_pulse"}, 64'(bus.cfg_done), 64'(0));
    check({tag, "_new_x"}, 64'(chanx_right_out), 64'(new_x));
  endtask

  task automatic clear_op();
    @(negedge prog_clk);
    bus.cfg_clear = 1'b1;
    m_count = 0;
    m_err   = 1'b0;
    @(negedge prog_clk);
    bus.cfg_clear = 1'b0;
    check("clear_err", 64'(bus.cfg_err), 64'(0));
  endtask

  task automatic reset_op();
    @(negedge prog_clk);
    prog_reset = 1'b1;
    m_shadow = '0;
    m_active = '0;
    m_count  = 0;
    m_err    = 1'b0;
    @(negedge prog_clk);
    @(negedge prog_clk);
    prog_reset = 1'b0;
  endtask

  task automatic load_commit(input string tag, input logic [NB-1:0] word);
    shift_bits(word, NB);
    commit_op(tag, 1'b0, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NB-1:0] w;
    // Reset with every input held at 1
    prog_reset      = 1'b1;
    chanx_right_in  = '1;
    chany_bottom_in = '1;
    right_pin       = '1;
    bottom_pin      = '1;
    bus.ccff_head   = 1'b1;
    bus.cfg_shift   = 1'b1;
    bus.cfg_commit  = 1'b1;
    bus.cfg_clear   = 1'b1;
    m_shadow = '0;
    m_active = '0;
    m_count  = 0;
    m_err    = 1'b0;
    repeat (3) @(negedge prog_clk);
    check("rst_x", 64'(chanx_right_out), 64'(0));
    check("rst_y", 64'(chany_bottom_out), 64'(0));
    check("rst_done", 64'(bus.cfg_done), 64'(0));
    check("rst_err", 64'(bus.cfg_err), 64'(0));
    check("rst_tail", 64'(bus.ccff_tail), 64'(0));
    bus.ccff_head  = 1'b0;
    bus.cfg_shift  = 1'b0;
    bus.cfg_commit = 1'b0;
    bus.cfg_clear  = 1'b0;
    @(negedge prog_clk);
    prog_reset = 1'b0;
    check_outputs("ones", '1, '1, '1, '1);

    // Every mux on the pin
    load_commit("c01", {18{2'b01}});
    check_random("pin", 3);

    // Every mux twisted, single bottom-channel track set
    load_commit("c10", {18{2'b10}});
    check_outputs("twist", W'($urandom()), 9'b0_0000_0001, W'($urandom()), W'($urandom()));
    check("twist_bit7", 64'(chanx_right_out), 64'(9'h080));
    check_random("twist", 2);

    // Every mux straight, then mixed codes
    load_commit("c11", {18{2'b11}});
    check_random("straight", 2);
    for (int k = 0; k < 2; k++) begin
      w = NB'({$urandom(), $urandom()});
      load_commit("cmix", w);
      check_random("mix", 3);
    end

    // Short load rejected, clear recovers
    shift_bits(NB'({$urandom(), $urandom()}), NB - 1);
    commit_op("c35", 1'b0, 1'b0);
    check_random("after35", 1);
    clear_op();
    load_commit("c36a", NB'({$urandom(), $urandom()}));
    check_random("after36a", 1);

    // Over-long load rejected; commit with shift in FULL accepted
    shift_bits(NB'({$urandom(), $urandom()}), NB + 1);
    commit_op("c37", 1'b0, 1'b0);
    clear_op();
    shift_bits(NB'({$urandom(), $urandom()}), NB);
    commit_op("cshift", 1'b1, 1'b0);
    check("cshift_tail", 64'(bus.ccff_tail), 64'(m_shadow[NB-1]));
    load_commit("c36b", NB'({$urandom(), $urandom()}));
    check_random("after36b", 1);

    // Clear coinciding with a commit in FULL wins
    shift_bits(NB'({$urandom(), $urandom()}), NB);
    commit_op("cclr", 1'b0, 1'b1);
    commit_op("cempty", 1'b0, 1'b0);
    clear_op();

    // Reset mid-shift discards the partial load
    shift_bits(NB'({$urandom(), $urandom()}), 10);
    reset_op();
    check_outputs("postrst", W'($urandom()), W'($urandom()), W'($urandom()), W'($urandom()));
    load_commit("crst", NB'({$urandom(), $urandom()}));
    check_random("afterrst", 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
